// File: rtl/mc_fetch_regs_pkg.sv
// Shared definitions for the multi-cycle MIPS fetch/register block and its
// controller: next-PC select encodings, opcode constants, instruction field
// bit positions and a sign-extension helper.
package mc_fetch_regs_pkg;

  // next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // opcodes used by the controller
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // instruction field bit positions
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int JIDX_HI   = 25;
  localparam int JIDX_LO   = 0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mc_fetch_regs_next_pc.sv
// mc_next_pc: combinational next-PC selection and branch resolution.
// Ports:
//   PCWrite, PCWriteCond, branch  controller strobes (branch=1 beq, 0 bne)
//   PCSrc                         next-PC source select
//   alu_result, alu_zero          combinational ALU outputs
//   alu_out, reg_a                holding registers
//   pc_hi                         pc[31:28] for the jump region
//   jump_index                    IR[25:0]
//   next_pc, taken, pc_en         resolved next PC and write enable
module mc_next_pc
  import mc_fetch_regs_pkg::*;
(
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        branch,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] alu_out,
  input  logic [31:0] reg_a,
  input  logic [3:0]  pc_hi,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc,
  output logic        taken,
  output logic        pc_en
);

  always_comb begin
    taken = branch ? alu_zero : ~alu_zero;
    // an unconditional write wins regardless of the branch outcome
    pc_en = PCWrite | (PCWriteCond & taken);
    next_pc = alu_result;
    case (PCSrc)
      PCSRC_ALU:    next_pc = alu_result;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = {pc_hi, jump_index, 2'b00};
      PCSRC_REG:    next_pc = reg_a;
      default:      next_pc = alu_result;
    endcase
  end

endmodule

// File: rtl/mc_fetch_regs.sv
// mc_fetch_regs: architectural and inter-cycle state of the multi-cycle MIPS
// datapath (PC, IR, MDR, A, B, ALUOut), plus memory address mux, instruction
// field decode, jal link value, retired-instruction counter and a sticky
// misaligned-PC fault flag.
// Ports:
//   clk, rst                     clock; async active-low reset
//   PCWrite..link, PCSrc         controller strobes
//   alu_result, alu_zero         combinational ALU outputs
//   rd_data1, rd_data2           register-file read ports
//   mem_rdata                    combinational memory read data
//   pc, mem_addr, instr          PC, memory address, IR
//   opcode..imm_sh2              IR field decodes
//   mdr, reg_a, reg_b, alu_out   holding registers
//   link_data, instret, pc_fault link value, retire count, fault flag
module mc_fetch_regs
  import mc_fetch_regs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             branch,
  input  logic             IRWrite,
  input  logic             IorD,
  input  logic             MemRead,
  input  logic             link,
  input  logic [1:0]       PCSrc,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic [31:0]      rd_data1,
  input  logic [31:0]      rd_data2,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      mem_addr,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic [5:0]       func,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      imm_sext,
  output logic [31:0]      imm_sh2,
  output logic [31:0]      mdr,
  output logic [31:0]      reg_a,
  output logic [31:0]      reg_b,
  output logic [31:0]      alu_out,
  output logic [31:0]      link_data,
  output logic [CNT_W-1:0] instret,
  output logic             pc_fault
);

  logic [31:0] next_pc;
  logic        taken;
  logic        pc_en;

  // link only steers the register-file write mux outside this block
  logic link_unused;
  assign link_unused = link;

  mc_next_pc u_next_pc (
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .branch      (branch),
    .PCSrc       (PCSrc),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_out     (alu_out),
    .reg_a       (reg_a),
    .pc_hi       (pc[31:28]),
    .jump_index  (instr[JIDX_HI:JIDX_LO]),
    .next_pc     (next_pc),
    .taken       (taken),
    .pc_en       (pc_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      mdr      <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      alu_out  <= '0;
      instret  <= '0;
      pc_fault <= 1'b0;
    end else begin
      if (pc_en) begin
        pc <= next_pc;
        // misaligned targets are still written; the flag records it
        if (next_pc[1:0] != 2'b00) pc_fault <= 1'b1;
      end
      if (IRWrite) begin
        instr   <= mem_rdata;
        instret <= instret + CNT_W'(1);
      end
      if (MemRead && IorD) mdr <= mem_rdata;
      reg_a   <= rd_data1;
      reg_b   <= rd_data2;
      alu_out <= alu_result;
    end
  end

  always_comb begin
    mem_addr  = IorD ? alu_out : pc;
    opcode    = instr[OPCODE_HI:OPCODE_LO];
    rs        = instr[RS_HI:RS_LO];
    rt        = instr[RT_HI:RT_LO];
    rd        = instr[RD_HI:RD_LO];
    func      = instr[FUNC_HI:FUNC_LO];
    imm_sext  = sext16(instr[IMM_HI:IMM_LO]);
    imm_sh2   = {imm_sext[29:0], 2'b00};
    link_data = pc;
  end

endmodule

// File: doc/mc_fetch_regs.md
# mc_fetch_regs

Architectural and inter-cycle state holder for the multi-cycle MIPS datapath, driven directly by the multi-cycle controller's control outputs. It owns the PC, IR, MDR, A, B and ALUOut registers, as well as the next-PC selection and branch-resolution logic. It also provides memory address muxing, instruction field decode for the controller, the jal link value, a retired-instruction counter and a sticky misaligned-PC fault flag.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.
- clk  in  1  single clock; all registers update on the rising edge.
- rst  in  1  asynchronous reset, active-low: 0 resets immediately, release synchronous to clk.
- PCWrite, PCWriteCond, branch, IRWrite, IorD, MemRead, link  in  1 each  controller strobes; branch=1 selects beq, 0 selects bne.
- PCSrc  in  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 reg_a.
- alu_result  in  32  combinational ALU output.
- alu_zero  in  1  combinational ALU zero flag.
- rd_data1, rd_data2  in  32  register-file read ports.
- mem_rdata  in  32  unified memory read data; memory read is combinational.
- pc  out  32  program counter.
- mem_addr  out  32  IorD ? alu_out : pc.
- instr  out  32  IR.
- opcode, func  out  6 each  IR[31:26], IR[5:0].
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- imm_sext  out  32  sign-extended IR[15:0].
- imm_sh2  out  32  imm_sext<<2.
- mdr, reg_a, reg_b, alu_out  out  32 each  holding registers.
- link_data  out  32  equals pc (already PC+4 in the jal state).
- instret  out  CNT_W  retired-instruction count.
- pc_fault  out  1  sticky misaligned-PC flag.

## Operation
- taken = branch ? alu_zero : ~alu_zero.
- pc_en = PCWrite | (PCWriteCond & taken).
- PCWrite has priority. When both PCWrite and PCWriteCond are set, the PC is written regardless of taken.
- next_pc by PCSrc:
  - 00: alu_result.
  - 01: alu_out (branch target computed in ID).
  - 10: {pc[31:28], IR[25:0], 2'b00}.
  - 11: reg_a.
- PCSrc 10 uses the IR value before any same-cycle IRWrite update.
- IR loads mem_rdata when IRWrite=1, otherwise holds.
- In the fetch cycle, IR captures the word at the old pc while pc advances to alu_result (PC+4) on the same edge.
- MDR loads mem_rdata when MemRead & IorD, i.e. data reads only; otherwise holds.
- reg_a, reg_b and alu_out load rd_data1, rd_data2 and alu_result every cycle, unconditionally.
- instret increments by 1 on each IRWrite edge and wraps modulo 2^CNT_W with no saturation.
- pc_fault sets when pc_en=1 and next_pc[1:0]!=2'b00. The misaligned value is still written to pc. pc_fault clears only on reset.
- link has no internal effect; link_data is continuously pc, and the register-file write mux uses it when link=1.

## Timing
- Reset values: pc=RESET_PC; IR, MDR, A, B, ALUOut, instret and pc_fault all 0. Decoded fields therefore read 0, so opcode=0.
- Reset asserted mid-instruction overrides all strobes in that cycle. The first edge after release executes the controller's IF state.
- One-cycle latency: every register output reflects inputs sampled at the preceding rising edge.
- mem_addr, the field decodes, imm_sext, imm_sh2, taken and next_pc are purely combinational.

## Structure
- Shared package (with the controller): PCSrc encodings PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10, PCSRC_REG=2'b11; opcode constants; the field bit-position constants.
- One natural sub-module, mc_next_pc: combinational next_pc, taken and pc_en logic.
- All registers live in the top module.

## Test plan
- Reset with RESET_PC=32'h40: hold rst=0 with all strobes high. Required: pc=32'h40, instr=0, instret=0, pc_fault=0. Release, then IRWrite=PCWrite=1, PCSrc=00, alu_result=32'h44, mem_rdata=32'h2008_0005. Required after the edge: pc=32'h44, instr=32'h2008_0005, opcode=6'h08, imm_sext=5, instret=1.
- beq taken and not taken: alu_out=32'h100, PCWriteCond=1, branch=1, PCSrc=01. With alu_zero=1, pc becomes 32'h100. With alu_zero=0, pc holds. With branch=0 (bne), the outcomes invert.
- Jump: pc=32'hA000_0004, IR=32'h0800_0010, PCWrite=1, PCSrc=10. Required: pc=32'hA000_0040.
- Jr and fault: reg_a=32'h0000_0203, PCWrite=1, PCSrc=11. Required: pc=32'h203 and pc_fault=1. pc_fault stays 1 after a later aligned write and clears only on rst=0.
- Load path: IorD=1, MemRead=1, alu_out=32'h80, mem_rdata=32'hDEAD_BEEF. Required: mem_addr=32'h80 and mdr=32'hDEAD_BEEF. With MemRead=1, IorD=0, mdr holds.
- Counter wrap with CNT_W=4: apply 16 IRWrite pulses. Required: instret returns to 0. Simultaneous PCWrite=PCWriteCond=1 with taken=0 still writes pc.
